airlock_seq: RTL

Parametrised bathysphere airlock sequencer: the successor to the single-chamber door/fill controller. It owns both doors and the chamber water level, and runs complete arrival (lake→lab) and departure (lab→lake) cycles from one request pulse. Fill, drain, door-travel and entry-wait times are configurable, and requests arriving while a cycle is running are queued. It sits between the operator switches/occupancy sensor and the door and pump drivers.

---
 rtl/airlock_pkg.sv | 31 +++
 rtl/dwell_timer.sv | 27 ++
 rtl/airlock_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/airlock_pkg.sv
// airlock_pkg: shared state codes, direction constants and dwell lookup for the airlock sequencer
//   state_t   : 4-bit sequencer state codes (also driven on the debug state port)
//   DIR_ARR/DIR_DEP : cycle direction encoding (arrival = lake->lab, departure = lab->lake)
//   dwell_of  : cycles a state dwells before its timer expires
package airlock_pkg;

    typedef enum logic [3:0] {
        S_RECOVER = 4'd0,
        S_IDLE    = 4'd1,
        S_FILL    = 4'd2,
        S_OPEN_O  = 4'd3,
        S_WAIT_O  = 4'd4,
        S_CLOSE_O = 4'd5,
        S_DRAIN   = 4'd6,
        S_OPEN_I  = 4'd7,
        S_WAIT_I  = 4'd8,
        S_CLOSE_I = 4'd9
    } state_t;

    localparam logic DIR_ARR = 1'b0;
    localparam logic DIR_DEP = 1'b1;

    // IDLE returns 1 so that its timer load value is simply zero
    function automatic int dwell_of(state_t s, int fill_cyc, int drain_cyc, int door_cyc, int wait_cyc);
        return (s == S_FILL) ? fill_cyc :
               (s == S_DRAIN || s == S_RECOVER) ? drain_cyc :
               (s == S_OPEN_O || s == S_CLOSE_O || s == S_OPEN_I || s == S_CLOSE_I) ? door_cyc :
               (s == S_WAIT_O || s == S_WAIT_I) ? wait_cyc : 1;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: loadable down-counter that flags when the current dwell has expired
//   clk, rst : clock, asynchronous active-high reset (counter returns to RST_VAL)
//   i_load   : load strobe, takes i_val on the next edge
//   i_val    : load value (dwell length minus one)
//   o_done   : high while the counter reads zero
module dwell_timer #(
    parameter int         W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= RST_VAL;
        else if (i_load) r_cnt <= i_val;
        else if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/airlock_seq.sv
// airlock_seq: two-door airlock sequencer running full arrival/departure cycles from one request pulse
//   clk, rst           : clock, asynchronous active-high reset
//   appr, dprt         : arrival / departure request pulses (pended until served)
//   occ                : chamber occupancy sensor
//   od_cmd, id_cmd     : outer / inner door drive open
//   fill_v, drain_v    : fill valve / drain pump
//   water              : chamber known full
//   busy               : sequencer not idle
//   appr_ack, dprt_ack : one-cycle pulse when a request is accepted
//   tmo                : one-cycle pulse when no craft entered in time
//   state              : current state code
module airlock_seq
    import airlock_pkg::*;
#(
    parameter int FILL_CYC  = 5,
    parameter int DRAIN_CYC = 5,
    parameter int DOOR_CYC  = 2,
    parameter int WAIT_CYC  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       appr,
    input  logic       dprt,
    input  logic       occ,
    output logic       od_cmd,
    output logic       id_cmd,
    output logic       fill_v,
    output logic       drain_v,
    output logic       water,
    output logic       busy,
    output logic       appr_ack,
    output logic       dprt_ack,
    output logic       tmo,
    output logic [3:0] state
);

    localparam int MAX_FD  = (FILL_CYC > DRAIN_CYC) ? FILL_CYC : DRAIN_CYC;
    localparam int MAX_DW  = (DOOR_CYC > WAIT_CYC) ? DOOR_CYC : WAIT_CYC;
    localparam int MAX_CYC = (MAX_FD > MAX_DW) ? MAX_FD : MAX_DW;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    state_t          r_state, w_nxt;
    logic            r_dir, r_last_dir, r_loaded, r_appr_pend, r_dprt_pend;
    logic            w_loaded, w_acc_a, w_acc_d, w_tmo, w_done;
    logic            w_req_a, w_req_d, w_pick_dep;
    logic [TW-1:0]   w_load_val;

    assign w_req_a    = r_appr_pend | appr;
    assign w_req_d    = r_dprt_pend | dprt;
    // on a tie the direction not served last goes first
    assign w_pick_dep = w_req_d & (~w_req_a | (r_last_dir == DIR_ARR));
    assign w_load_val = TW'(dwell_of(w_nxt, FILL_CYC, DRAIN_CYC, DOOR_CYC, WAIT_CYC) - 1);
    assign state      = r_state;

    dwell_timer #(.W(TW), .RST_VAL(TW'(DRAIN_CYC - 1))) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_nxt != r_state),
        .i_val  (w_load_val),
        .o_done (w_done)
    );

    always_comb begin
        w_nxt    = r_state;
        w_loaded = r_loaded;
        w_acc_a  = 1'b0;
        w_acc_d  = 1'b0;
        w_tmo    = 1'b0;
        case (r_state)
            S_RECOVER: if (w_done) w_nxt = S_IDLE;
            S_IDLE: if (w_req_a | w_req_d) begin
                w_acc_d  = w_pick_dep;
                w_acc_a  = ~w_pick_dep;
                w_loaded = 1'b0;
                w_nxt    = w_pick_dep ? S_OPEN_I : S_FILL;
            end
            S_FILL:    if (w_done) w_nxt = S_OPEN_O;
            S_OPEN_O:  if (w_done) w_nxt = S_WAIT_O;
            // empty chamber waits for entry (bounded); loaded chamber waits for exit (unbounded)
            S_WAIT_O, S_WAIT_I: if (r_loaded ? ~occ : (occ | w_done)) begin
                w_loaded = r_loaded | occ;
                w_tmo    = ~r_loaded & ~occ;
                w_nxt    = (r_state == S_WAIT_O) ? S_CLOSE_O : S_CLOSE_I;
            end
            S_CLOSE_O: if (w_done) w_nxt = S_DRAIN;
            S_DRAIN:   if (w_done) w_nxt = (r_dir == DIR_ARR && r_loaded) ? S_OPEN_I : S_IDLE;
            S_OPEN_I:  if (w_done) w_nxt = S_WAIT_I;
            S_CLOSE_I: if (w_done) w_nxt = (r_dir == DIR_DEP && r_loaded) ? S_FILL : S_IDLE;
            default:   w_nxt = S_RECOVER;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RECOVER;
            r_dir       <= DIR_ARR;
            r_last_dir  <= DIR_DEP;
            r_loaded    <= 1'b0;
            r_appr_pend <= 1'b0;
            r_dprt_pend <= 1'b0;
            od_cmd      <= 1'b0;
            id_cmd      <= 1'b0;
            fill_v      <= 1'b0;
            drain_v     <= 1'b1;
            water       <= 1'b0;
            busy        <= 1'b0;
            appr_ack    <= 1'b0;
            dprt_ack    <= 1'b0;
            tmo         <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_loaded    <= w_loaded;
            r_dir       <= (w_acc_a | w_acc_d) ? w_acc_d : r_dir;
            r_last_dir  <= (w_acc_a | w_acc_d) ? w_acc_d : r_last_dir;
            // a request still high during its own ack cycle is the same request, not a new one
            r_appr_pend <= ~w_acc_a & (r_appr_pend | (appr & ~appr_ack));
            r_dprt_pend <= ~w_acc_d & (r_dprt_pend | (dprt & ~dprt_ack));
            od_cmd      <= (w_nxt == S_OPEN_O) | (w_nxt == S_WAIT_O);
            id_cmd      <= (w_nxt == S_OPEN_I) | (w_nxt == S_WAIT_I);
            fill_v      <= (w_nxt == S_FILL);
            drain_v     <= (w_nxt == S_DRAIN) | (w_nxt == S_RECOVER);
            water       <= (r_state == S_FILL && w_nxt != S_FILL) |
                           (water & ~(r_state == S_DRAIN && w_nxt != S_DRAIN));
            busy        <= (w_nxt != S_IDLE);
            appr_ack    <= w_acc_a;
            dprt_ack    <= w_acc_d;
            tmo         <= w_tmo;
        end
    end

endmodule
